mem_access: RTL
===============

# mem_access

Memory-access stage sitting directly downstream of the EX stage. It consumes EX's registered outputs: aluop, write-back controls, ALU result used as effective address, and store data. It performs byte-serial loads and stores over the 8-bit RAM port, stalling the upstream pipeline while busy, and delivers write-back data to the MEM/WB side. Non-memory ops pass through with one cycle of latency.

## Interface
- No parameters. Opcode encodings come from `macro.vh`: ALU_LB/LH/LW/LBU/LHU_OP and ALU_SB/SH/SW_OP.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_EXMEM_i  in  1  EX output holds a live instruction.
- aluop_EXMEM_i  in  `AluOpBus  operation from EX.
- wreg_EXMEM_i  in  1  destination write enable.
- waddr_EXMEM_i  in  5  destination register.
- alurslt_EXMEM_i  in  32  ALU result; the effective address for memory ops.
- storedata_EXMEM_i  in  32  store data.
- stall_o  in/out: out  1  hold request to EX/EXMEM; inputs must stay stable while high.
- mem_a_o  out  32  RAM byte address.
- mem_dout_o  out  8  RAM write byte.
- mem_wr_o  out  1  RAM write strobe; 1 = write.
- mem_din_i  in  8  RAM read byte. Valid one cycle after its address is driven.
- valid_MEMWB_o  out  1  one-cycle pulse per completed instruction.
- wreg_MEMWB_o  out  1  write enable to write-back.
- waddr_MEMWB_o  out  5  destination register.
- wdata_MEMWB_o  out  32  write-back data.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: issuing bytes; byte counter cnt runs 0..n-1.
  - WAIT: loads only; capture the last byte.
- Access size n: 1 for B/BU, 2 for H/HU, 4 for W.
- IDLE with valid_EXMEM_i and a load/store op:
  - latch op, address, store data, wreg, waddr;
  - cnt←0; go to ACCESS.
- IDLE with valid_EXMEM_i and a non-memory op:
  - register the outputs: valid=1, wreg, waddr, wdata=alurslt.
- IDLE with no valid instruction: valid_MEMWB_o←0.
- ACCESS, per cycle (mem outputs registered, cnt=k):
  - mem_a_o = addr+k (32-bit wrap; no alignment check; little-endian);
  - stores: mem_wr_o=1 and mem_dout_o=storedata[8k+7:8k];
  - loads: mem_wr_o=0.
- Store after its last byte: back to IDLE. valid_MEMWB_o=1 next cycle, with wreg_MEMWB_o=0 and wdata=0.
- Load after its last byte: go to WAIT.
- Load byte capture: byte k is captured from mem_din_i the cycle after it is issued.
- Load in WAIT: assemble result from captured bytes plus the live mem_din_i (last byte) and register it into wdata_MEMWB_o.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - Set valid=1, wreg and waddr from the latch, then return to IDLE.
- stall_o is combinational. It is high when:
  - the state is IDLE, valid_EXMEM_i is set and the op is a memory op; or
  - the state is ACCESS and cnt≠n-1 (any op); or
  - the state is ACCESS and cnt=n-1 and the op is a load.
- stall_o is low when:
  - in WAIT;
  - in the last ACCESS cycle of a store;
  - when stall_o is low, EX advances on that edge, which is also the edge the result is registered.
- Inputs are ignored outside IDLE.
- Reset (asserted, async, including mid-access):
  - state←IDLE, cnt←0;
  - all registered outputs become 0 immediately: mem_wr_o=0, mem_a_o=0, mem_dout_o=0, valid/wreg/waddr/wdata=0;
  - stall_o forced 0 while rst is low;
  - the partial access is abandoned with no further writes.

## Timing
Instruction accepted in cycle A.
- Non-memory op:
  - outputs valid in A+1;
  - stall_o never asserted; back-to-back throughput of 1 per cycle.
- Store of n bytes:
  - writes in cycles A+1..A+n;
  - stall_o high A..A+n-1, low in A+n;
  - valid_MEMWB_o high in A+n+1.
- Load of n bytes:
  - addresses in A+1..A+n;
  - mem_din_i bytes in A+2..A+n+1;
  - stall_o high A..A+n, low in A+n+1 (WAIT);
  - valid_MEMWB_o high in A+n+2;
  - LW total: 6 cycles from acceptance to result.
- Next instruction is presented in the cycle after stall_o falls. If it is a memory op it is accepted there, with no idle gap.

## Test plan
- Non-memory op: ADD result 0x0000_0007, waddr 5, three back-to-back ops.
  - Each valid_MEMWB_o appears 1 cycle later.
  - wdata=7, stall_o never high.
- SW addr 0x100, data 0xDEADBEEF:
  - writes 0xEF,0xBE,0xAD,0xDE to 0x100..0x103 in A+1..A+4;
  - stall_o low in A+4; valid pulse in A+5 with wreg=0.
- LB vs LBU from a byte holding 0x80:
  - LB gives wdata 0xFFFF_FF80, LBU gives 0x0000_0080.
  - valid in A+3 in both cases.
- LH at 0xFFFF_FFFF, holding 0x34 at 0xFFFF_FFFF and 0x92 at 0x0000_0000:
  - address wraps to 0; wdata 0xFFFF_9234.
- LW followed immediately by SB:
  - LW result in A+6;
  - SB accepted in A+6, with its write in A+7.
- rst pulsed low during the 2nd byte of SW:
  - mem_wr_o drops at once, no further bytes are written;
  - all outputs read 0, state IDLE;
  - after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit RAM port, with a
// one-cycle pass-through for non-memory ops and an upstream stall while busy.
package mem_access_pkg;
    localparam int unsigned ALU_OP_W = 8;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD_OP = 8'h01;
    localparam logic [ALU_OP_W-1:0] ALU_LB_OP  = 8'h10;
    localparam logic [ALU_OP_W-1:0] ALU_LH_OP  = 8'h11;
    localparam logic [ALU_OP_W-1:0] ALU_LW_OP  = 8'h12;
    localparam logic [ALU_OP_W-1:0] ALU_LBU_OP = 8'h13;
    localparam logic [ALU_OP_W-1:0] ALU_LHU_OP = 8'h14;
    localparam logic [ALU_OP_W-1:0] ALU_SB_OP  = 8'h18;
    localparam logic [ALU_OP_W-1:0] ALU_SH_OP  = 8'h19;
    localparam logic [ALU_OP_W-1:0] ALU_SW_OP  = 8'h1A;

    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   sdata;
        logic                wreg;
        logic [REG_W-1:0]    waddr;
    } mem_req_t;
endpackage

module mem_access
    import mem_access_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_EXMEM_i,
    input  logic [ALU_OP_W-1:0] aluop_EXMEM_i,
    input  logic                wreg_EXMEM_i,
    input  logic [REG_W-1:0]    waddr_EXMEM_i,
    input  logic [DATA_W-1:0]   alurslt_EXMEM_i,
    input  logic [DATA_W-1:0]   storedata_EXMEM_i,
    output logic                stall_o,
    output logic [ADDR_W-1:0]   mem_a_o,
    output logic [7:0]          mem_dout_o,
    output logic                mem_wr_o,
    input  logic [7:0]          mem_din_i,
    output logic                valid_MEMWB_o,
    output logic                wreg_MEMWB_o,
    output logic [REG_W-1:0]    waddr_MEMWB_o,
    output logic [DATA_W-1:0]   wdata_MEMWB_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_LB_OP, ALU_LH_OP, ALU_LW_OP, ALU_LBU_OP, ALU_LHU_OP};
    endfunction

    function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_SB_OP, ALU_SH_OP, ALU_SW_OP};
    endfunction

    // Index of the final byte: n-1 for an n-byte access.
    function automatic logic [1:0] last_idx(input logic [ALU_OP_W-1:0] op);
        logic [1:0] r;
        r = 2'd0;
        if (op inside {ALU_LW_OP, ALU_SW_OP})
            r = 2'd3;
        else if (op inside {ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP})
            r = 2'd1;
        return r;
    endfunction

    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic [1:0]        last_cnt;
    mem_req_t          req, req_n;
    logic [23:0]       bytes, bytes_n;
    logic [ADDR_W-1:0] mem_a_n;
    logic [7:0]        mem_dout_n;
    logic              mem_wr_n;
    logic              valid_n, wreg_n;
    logic [REG_W-1:0]  waddr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              stall_c;

    assign last_cnt = last_idx(req.op);
    assign stall_o  = stall_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            req           <= '0;
            bytes         <= '0;
            mem_a_o       <= '0;
            mem_dout_o    <= '0;
            mem_wr_o      <= 1'b0;
            valid_MEMWB_o <= 1'b0;
            wreg_MEMWB_o  <= 1'b0;
            waddr_MEMWB_o <= '0;
            wdata_MEMWB_o <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            req           <= req_n;
            bytes         <= bytes_n;
            mem_a_o       <= mem_a_n;
            mem_dout_o    <= mem_dout_n;
            mem_wr_o      <= mem_wr_n;
            valid_MEMWB_o <= valid_n;
            wreg_MEMWB_o  <= wreg_n;
            waddr_MEMWB_o <= waddr_n;
            wdata_MEMWB_o <= wdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        req_n      = req;
        bytes_n    = bytes;
        mem_a_n    = mem_a_o;
        mem_dout_n = mem_dout_o;
        mem_wr_n   = 1'b0;
        valid_n    = 1'b0;
        wreg_n     = wreg_MEMWB_o;
        waddr_n    = waddr_MEMWB_o;
        wdata_n    = wdata_MEMWB_o;
        stall_c    = 1'b0;

        case (state)
            IDLE: begin
                if (valid_EXMEM_i) begin
                    if (is_load(aluop_EXMEM_i) || is_store(aluop_EXMEM_i)) begin
                        // Byte 0 goes out on the acceptance edge.
                        stall_c    = 1'b1;
                        req_n      = '{op: aluop_EXMEM_i, addr: alurslt_EXMEM_i,
                                       sdata: storedata_EXMEM_i, wreg: wreg_EXMEM_i,
                                       waddr: waddr_EXMEM_i};
                        cnt_n      = '0;
                        mem_a_n    = alurslt_EXMEM_i;
                        mem_dout_n = storedata_EXMEM_i[7:0];
                        mem_wr_n   = is_store(aluop_EXMEM_i);
                        state_n    = ACCESS;
                    end else begin
                        valid_n = 1'b1;
                        wreg_n  = wreg_EXMEM_i;
                        waddr_n = waddr_EXMEM_i;
                        wdata_n = alurslt_EXMEM_i;
                    end
                end
            end
            ACCESS: begin
                stall_c = (cnt != last_cnt) || is_load(req.op);
                // Read data lags its address by one cycle.
                case (cnt)
                    2'd1:    bytes_n[7:0]   = mem_din_i;
                    2'd2:    bytes_n[15:8]  = mem_din_i;
                    2'd3:    bytes_n[23:16] = mem_din_i;
                    default: bytes_n        = bytes;
                endcase
                if (cnt == last_cnt) begin
                    cnt_n = '0;
                    if (is_store(req.op)) begin
                        state_n = IDLE;
                        valid_n = 1'b1;
                        wreg_n  = 1'b0;
                        waddr_n = req.waddr;
                        wdata_n = '0;
                    end else begin
                        state_n = WAIT;
                    end
                end else begin
                    cnt_n      = cnt + 2'd1;
                    mem_a_n    = req.addr + ADDR_W'(cnt_n);
                    mem_dout_n = 8'(req.sdata >> {cnt_n, 3'b000});
                    mem_wr_n   = is_store(req.op);
                end
            end
            WAIT: begin
                case (req.op)
                    ALU_LB_OP:  wdata_n = {{24{mem_din_i[7]}}, mem_din_i};
                    ALU_LBU_OP: wdata_n = {24'h0, mem_din_i};
                    ALU_LH_OP:  wdata_n = {{16{mem_din_i[7]}}, mem_din_i, bytes[7:0]};
                    ALU_LHU_OP: wdata_n = {16'h0, mem_din_i, bytes[7:0]};
                    default:    wdata_n = {mem_din_i, bytes};
                endcase
                valid_n = 1'b1;
                wreg_n  = req.wreg;
                waddr_n = req.waddr;
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (!rst)
            stall_c = 1'b0;
    end
endmodule
